// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
//
// Sequencing FSM for the multicycle (non-pipelined) MIPS core. It steps the
// shared memory, IR, PC, ALU and register-file controls one state per clock.
// It decodes R-format, lw, sw, beq, bne and j. It stalls on a memory-ready
// handshake, pulses `retire` when an instruction completes, and keeps a
// wrapping count of retired instructions.
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   asynchronous, active-high reset
//   opcode       in   IR[31:26], valid from DECODE onward
//   mem_ready    in   memory completes the current read/write this cycle
//   PCWrite      out  unconditional PC load
//   PCWriteCond  out  conditional PC load (branch)
//   BranchNe     out  1 = branch on zero=0 (bne), 0 = branch on zero=1 (beq)
//   IorD         out  memory address select: 0 = PC, 1 = ALUOut
//   MemRead      out  memory read strobe
//   MemWrite     out  memory write strobe
//   IRWrite      out  instruction register load
//   MemtoReg     out  register write data: 1 = MDR, 0 = ALUOut
//   RegDst       out  destination register: 1 = rd, 0 = rt
//   RegWrite     out  register file write
//   ALUSrcA      out  ALU A: 0 = PC, 1 = rs data
//   ALUSrcB      out  ALU B: 00 rt, 01 const 4, 10 sign-ext imm, 11 imm<<2
//   ALUOp        out  00 add, 01 subtract, 10 funct field
//   PCSource     out  next PC: 00 ALU result, 01 ALUOut, 10 jump target
//   retire       out  one-cycle pulse when an instruction completes
//   illegal_op   out  one-cycle pulse on an unsupported opcode
//   instr_count  out  retired-instruction count (wraps silently)
//   state        out  current state code, for debug
// -----------------------------------------------------------------------------
module multicycle_control #(
    parameter logic [5:0] OP_R   = 6'b000000,
    parameter logic [5:0] OP_LW  = 6'b100011,
    parameter logic [5:0] OP_SW  = 6'b101011,
    parameter logic [5:0] OP_BEQ = 6'b000100,
    parameter logic [5:0] OP_BNE = 6'b000101,
    parameter logic [5:0] OP_J   = 6'b000010,
    parameter int         CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             BranchNe,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemtoReg,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       PCSource,
    output logic             retire,
    output logic             illegal_op,
    output logic [CNT_W-1:0] instr_count,
    output logic [3:0]       state
);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        FETCH     = 4'd1,
        DECODE    = 4'd2,
        MEM_ADDR  = 4'd3,
        MEM_READ  = 4'd4,
        MEM_WB    = 4'd5,
        MEM_WRITE = 4'd6,
        EXECUTE   = 4'd7,
        R_WB      = 4'd8,
        BRANCH    = 4'd9,
        JUMP      = 4'd10,
        ILLEGAL   = 4'd11
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of process ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        count_d = retire ? count_q + CNT_W'(1) : count_q;
    end

    // NOTE: every output and state_d gets a default before the case, so no
    // path through the block leaves a signal unassigned (no latches).
    always_comb begin
        state_d     = IDLE;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        BranchNe    = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        PCSource    = 2'b00;
        retire      = 1'b0;
        illegal_op  = 1'b0;

        case (state_q)
            IDLE: begin
                state_d = FETCH;
            end

            FETCH: begin
                // PC+4 is computed in the ALU alongside the read; IR and PC
                // only load on the cycle the memory actually delivers.
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
                state_d = mem_ready ? DECODE : FETCH;
            end

            DECODE: begin
                // Speculatively form the branch target into ALUOut.
                ALUSrcB = 2'b11;
                if (opcode == OP_LW || opcode == OP_SW) begin
                    state_d = MEM_ADDR;
                end else if (opcode == OP_R) begin
                    state_d = EXECUTE;
                end else if (opcode == OP_BEQ || opcode == OP_BNE) begin
                    state_d = BRANCH;
                end else if (opcode == OP_J) begin
                    state_d = JUMP;
                end else begin
                    state_d = ILLEGAL;
                end
            end

            MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = (opcode == OP_LW) ? MEM_READ : MEM_WRITE;
            end

            MEM_READ: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                state_d = mem_ready ? MEM_WB : MEM_READ;
            end

            MEM_WB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
                retire   = 1'b1;
                state_d  = FETCH;
            end

            MEM_WRITE: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                retire   = mem_ready;
                state_d  = mem_ready ? FETCH : MEM_WRITE;
            end

            EXECUTE: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
                state_d = R_WB;
            end

            R_WB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
                retire   = 1'b1;
                state_d  = FETCH;
            end

            BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                BranchNe    = (opcode == OP_BNE);
                retire      = 1'b1;
                state_d     = FETCH;
            end

            JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
                retire   = 1'b1;
                state_d  = FETCH;
            end

            ILLEGAL: begin
                // PC already advanced in FETCH, so the bad word is skipped.
                illegal_op = 1'b1;
                state_d    = FETCH;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign instr_count = count_q;
    assign state       = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control
//
// Directed, table-driven bench for multicycle_control. Inputs are driven on the
// falling edge and outputs sampled 1 time unit later, so each vector checks the
// Moore outputs of the state entered at the preceding rising edge. Hand-written
// sequences cover a truly asynchronous reset in the middle of a memory stall
// and counter wrap-around (on a second, narrow-counter instance).
// -----------------------------------------------------------------------------
module tb_multicycle_control;

    // Control word layout used for comparison.
    localparam logic [18:0] B_PCW   = 19'd1 << 18;
    localparam logic [18:0] B_PCWC  = 19'd1 << 17;
    localparam logic [18:0] B_BNE   = 19'd1 << 16;
    localparam logic [18:0] B_IORD  = 19'd1 << 15;
    localparam logic [18:0] B_MR    = 19'd1 << 14;
    localparam logic [18:0] B_MW    = 19'd1 << 13;
    localparam logic [18:0] B_IRW   = 19'd1 << 12;
    localparam logic [18:0] B_M2R   = 19'd1 << 11;
    localparam logic [18:0] B_RD    = 19'd1 << 10;
    localparam logic [18:0] B_RW    = 19'd1 << 9;
    localparam logic [18:0] B_SRCA  = 19'd1 << 8;
    localparam logic [18:0] SB_4    = 19'd1 << 6;
    localparam logic [18:0] SB_IMM  = 19'd2 << 6;
    localparam logic [18:0] SB_SHL  = 19'd3 << 6;
    localparam logic [18:0] OP_SUB  = 19'd1 << 4;
    localparam logic [18:0] OP_FN   = 19'd2 << 4;
    localparam logic [18:0] PS_AO   = 19'd1 << 2;
    localparam logic [18:0] PS_JT   = 19'd2 << 2;
    localparam logic [18:0] B_RET   = 19'd1 << 1;
    localparam logic [18:0] B_ILL   = 19'd1;

    // Expected control word per state, derived by hand from the state table.
    localparam logic [18:0] C_IDLE   = 19'd0;
    localparam logic [18:0] C_F_STL  = B_MR | SB_4;
    localparam logic [18:0] C_F_RDY  = B_MR | SB_4 | B_IRW | B_PCW;
    localparam logic [18:0] C_DEC    = SB_SHL;
    localparam logic [18:0] C_MADDR  = B_SRCA | SB_IMM;
    localparam logic [18:0] C_MREAD  = B_MR | B_IORD;
    localparam logic [18:0] C_MWB    = B_RW | B_M2R | B_RET;
    localparam logic [18:0] C_MW_STL = B_MW | B_IORD;
    localparam logic [18:0] C_MW_RDY = B_MW | B_IORD | B_RET;
    localparam logic [18:0] C_EXE    = B_SRCA | OP_FN;
    localparam logic [18:0] C_RWB    = B_RW | B_RD | B_RET;
    localparam logic [18:0] C_BEQ    = B_SRCA | OP_SUB | B_PCWC | PS_AO | B_RET;
    localparam logic [18:0] C_BNE    = C_BEQ | B_BNE;
    localparam logic [18:0] C_JMP    = B_PCW | PS_JT | B_RET;
    localparam logic [18:0] C_ILL    = B_ILL;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  opcode = 6'h00;
    logic        mem_ready = 1'b1;
    logic        PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite;
    logic        IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA;
    logic [1:0]  ALUSrcB, ALUOp, PCSource;
    logic        retire, illegal_op;
    logic [15:0] instr_count;
    logic [3:0]  state;

    // Second instance with a 4-bit counter to reach wrap-around quickly.
    logic        w_reset = 1'b1;
    logic [5:0]  w_opcode = 6'h02;
    logic        w_mem_ready = 1'b1;
    logic        w_PCWrite, w_PCWriteCond, w_BranchNe, w_IorD, w_MemRead;
    logic        w_MemWrite, w_IRWrite, w_MemtoReg, w_RegDst, w_RegWrite;
    logic        w_ALUSrcA;
    logic [1:0]  w_ALUSrcB, w_ALUOp, w_PCSource;
    logic        w_retire, w_illegal_op;
    logic [3:0]  w_instr_count;
    logic [3:0]  w_state;

    always #5 clk = ~clk;

    multicycle_control dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .BranchNe(BranchNe),
        .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
        .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUOp(ALUOp), .PCSource(PCSource), .retire(retire),
        .illegal_op(illegal_op), .instr_count(instr_count), .state(state)
    );

    multicycle_control #(.CNT_W(4)) dut_w (
        .clk(clk), .reset(w_reset), .opcode(w_opcode), .mem_ready(w_mem_ready),
        .PCWrite(w_PCWrite), .PCWriteCond(w_PCWriteCond), .BranchNe(w_BranchNe),
        .IorD(w_IorD), .MemRead(w_MemRead), .MemWrite(w_MemWrite),
        .IRWrite(w_IRWrite), .MemtoReg(w_MemtoReg), .RegDst(w_RegDst),
        .RegWrite(w_RegWrite), .ALUSrcA(w_ALUSrcA), .ALUSrcB(w_ALUSrcB),
        .ALUOp(w_ALUOp), .PCSource(w_PCSource), .retire(w_retire),
        .illegal_op(w_illegal_op), .instr_count(w_instr_count), .state(w_state)
    );

    logic [18:0] ctrl_act;
    assign ctrl_act = {PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite,
                       IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB,
                       ALUOp, PCSource, retire, illegal_op};

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic        rdy;
        logic [3:0]  st;
        logic [18:0] ctrl;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs[$];
    int   n_applied = 0;
    int   n_miss    = 0;

    function automatic void add(input logic rst, input logic [5:0] op,
                                input logic rdy, input logic [3:0] st,
                                input logic [18:0] ctrl, input logic [15:0] cnt);
        vec_t v;
        v.rst = rst; v.op = op; v.rdy = rdy; v.st = st; v.ctrl = ctrl; v.cnt = cnt;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_applied++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    initial begin
        //  rst  op     rdy  state  ctrl       count
        add(1, 6'h00, 1, 4'd0,  C_IDLE,   16'd0);  // 0  reset held
        add(0, 6'h00, 1, 4'd0,  C_IDLE,   16'd0);  // 1  released, IDLE
        add(0, 6'h00, 1, 4'd1,  C_F_RDY,  16'd0);  // 2  R: FETCH
        add(0, 6'h00, 1, 4'd2,  C_DEC,    16'd0);  // 3  DECODE
        add(0, 6'h00, 1, 4'd7,  C_EXE,    16'd0);  // 4  EXECUTE
        add(0, 6'h00, 1, 4'd8,  C_RWB,    16'd0);  // 5  R_WB
        add(0, 6'h23, 1, 4'd1,  C_F_RDY,  16'd1);  // 6  lw: FETCH
        add(0, 6'h23, 1, 4'd2,  C_DEC,    16'd1);  // 7
        add(0, 6'h23, 1, 4'd3,  C_MADDR,  16'd1);  // 8
        add(0, 6'h23, 0, 4'd4,  C_MREAD,  16'd1);  // 9  stall 1
        add(0, 6'h23, 0, 4'd4,  C_MREAD,  16'd1);  // 10 stall 2
        add(0, 6'h23, 1, 4'd4,  C_MREAD,  16'd1);  // 11 ready
        add(0, 6'h23, 1, 4'd5,  C_MWB,    16'd1);  // 12 MEM_WB
        add(0, 6'h2B, 1, 4'd1,  C_F_RDY,  16'd2);  // 13 sw: FETCH
        add(0, 6'h2B, 1, 4'd2,  C_DEC,    16'd2);  // 14
        add(0, 6'h2B, 1, 4'd3,  C_MADDR,  16'd2);  // 15
        add(0, 6'h2B, 1, 4'd6,  C_MW_RDY, 16'd2);  // 16 MEM_WRITE
        add(0, 6'h05, 1, 4'd1,  C_F_RDY,  16'd3);  // 17 bne: FETCH
        add(0, 6'h05, 1, 4'd2,  C_DEC,    16'd3);  // 18
        add(0, 6'h05, 1, 4'd9,  C_BNE,    16'd3);  // 19 BRANCH
        add(0, 6'h04, 1, 4'd1,  C_F_RDY,  16'd4);  // 20 beq: FETCH
        add(0, 6'h04, 1, 4'd2,  C_DEC,    16'd4);  // 21
        add(0, 6'h04, 1, 4'd9,  C_BEQ,    16'd4);  // 22 BRANCH
        add(0, 6'h02, 1, 4'd1,  C_F_RDY,  16'd5);  // 23 j: FETCH
        add(0, 6'h02, 1, 4'd2,  C_DEC,    16'd5);  // 24
        add(0, 6'h02, 1, 4'd10, C_JMP,    16'd5);  // 25 JUMP
        add(0, 6'h3F, 1, 4'd1,  C_F_RDY,  16'd6);  // 26 illegal: FETCH
        add(0, 6'h3F, 1, 4'd2,  C_DEC,    16'd6);  // 27
        add(0, 6'h3F, 1, 4'd11, C_ILL,    16'd6);  // 28 ILLEGAL
        add(0, 6'h23, 1, 4'd1,  C_F_RDY,  16'd6);  // 29 lw, count unchanged
        add(0, 6'h23, 1, 4'd2,  C_DEC,    16'd6);  // 30
        add(0, 6'h23, 1, 4'd3,  C_MADDR,  16'd6);  // 31
        add(0, 6'h23, 0, 4'd4,  C_MREAD,  16'd6);  // 32 stall
        add(1, 6'h23, 0, 4'd0,  C_IDLE,   16'd0);  // 33 reset, no edge yet
        add(0, 6'h2B, 0, 4'd0,  C_IDLE,   16'd0);  // 34 IDLE one cycle
        add(0, 6'h2B, 0, 4'd1,  C_F_STL,  16'd0);  // 35 FETCH stall
        add(0, 6'h2B, 1, 4'd1,  C_F_RDY,  16'd0);  // 36 FETCH ready
        add(0, 6'h2B, 1, 4'd2,  C_DEC,    16'd0);  // 37
        add(0, 6'h2B, 0, 4'd3,  C_MADDR,  16'd0);  // 38
        add(0, 6'h2B, 0, 4'd6,  C_MW_STL, 16'd0);  // 39 MEM_WRITE stall
        add(0, 6'h2B, 1, 4'd6,  C_MW_RDY, 16'd0);  // 40 MEM_WRITE ready
        add(0, 6'h23, 1, 4'd1,  C_F_RDY,  16'd1);  // 41 lw: FETCH

        foreach (vecs[i]) begin
            @(negedge clk);
            reset     = vecs[i].rst;
            opcode    = vecs[i].op;
            mem_ready = vecs[i].rdy;
            #1;
            check($sformatf("v%0d state", i), 32'(state), 32'(vecs[i].st));
            check($sformatf("v%0d ctrl", i), 32'(ctrl_act), 32'(vecs[i].ctrl));
            check($sformatf("v%0d count", i), 32'(instr_count), 32'(vecs[i].cnt));
        end

        // Asynchronous reset mid-cycle, in the middle of a MEM_READ stall.
        @(negedge clk);                       // DECODE
        @(negedge clk); mem_ready = 1'b0;     // MEM_ADDR
        @(negedge clk); #1;                   // MEM_READ, stalled
        check("stall state", 32'(state), 32'd4);
        check("stall ctrl", 32'(ctrl_act), 32'(C_MREAD));
        #2 reset = 1'b1;
        #1;
        check("async rst state", 32'(state), 32'd0);
        check("async rst ctrl", 32'(ctrl_act), 32'(C_IDLE));
        check("async rst count", 32'(instr_count), 32'd0);
        @(negedge clk); reset = 1'b0; mem_ready = 1'b1; #1;
        check("post rst idle", 32'(state), 32'd0);
        @(negedge clk); #1;
        check("post rst fetch", 32'(state), 32'd1);

        // Counter wrap on the 4-bit instance: back-to-back jumps, one retire
        // every 3 cycles; after jump n the count reads n mod 16 in cycle 3n+1.
        @(negedge clk); w_reset = 1'b0; #1;
        check("wrap idle", 32'(w_state), 32'd0);
        for (int c = 1; c <= 49; c++) begin
            @(negedge clk); #1;
            if (c == 46) begin
                check("wrap max", 32'(w_instr_count), 32'd15);
                check("wrap max state", 32'(w_state), 32'd1);
            end
            if (c == 49) begin
                check("wrap zero", 32'(w_instr_count), 32'd0);
                check("wrap zero state", 32'(w_state), 32'd1);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
        $finish;
    end

endmodule
